// File: rtl/seq_det_ctrl_pkg.sv
// Shared types and constants for the serial pattern detector.
package seq_det_ctrl_pkg;

  // Controller states: waiting for a word, or serialising one.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Width of the target pattern and of the bit history window.
  localparam int PAT_W = 4;

  // Width of the history fill counter (counts 0..PAT_W).
  localparam int FILL_W = $clog2(PAT_W + 1);

endpackage : seq_det_ctrl_pkg

// File: rtl/seq_det_ctrl_seq_match.sv
// Bit history window and pattern compare for seq_det_ctrl.
// History and fill level survive across words, so a pattern may straddle
// a word boundary; only clr or rst empties the window.
module seq_match
  import seq_det_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en_i,
  input  logic             bit_i,
  input  logic [PAT_W-1:0] pattern_i,
  output logic             match_o
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  hist_q;
  logic [PAT_W-1:0]  hist_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;

  // Next history/fill and the match decision for the bit being consumed.
  always_comb begin
    hist_d  = {hist_q[PAT_W-2:0], bit_i};
    fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    match_o = shift_en_i && (fill_q >= FILL_LAST) && (hist_d == pattern_i);
  end

  // History window register; clr empties it like reset does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clr) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en_i) begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule : seq_match

// File: rtl/seq_det_ctrl.sv
// Serial pattern detector: accepts a parallel word, shifts it out MSB first
// through a 4-bit history window and counts overlapping pattern matches.
// Optional threshold interrupt is built only when SEQ_DET_IRQ_EN is defined;
// otherwise irq is tied low and threshold is ignored.
//
// Handshake: a word transfers on any rising edge where in_valid and in_ready
// are both high. in_ready is high only in IDLE with clr low; in_valid while
// busy is ignored and has no side effect. in_data/pattern are sampled on the
// transfer edge only.
module seq_det_ctrl
  import seq_det_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PAT_W-1:0]  pattern,
  input  logic [CNT_W-1:0]  threshold,
  output logic              busy,
  output logic              det,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic              irq,
  output state_e            dbg_state
);

  localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  data_q;
  logic [PAT_W-1:0]   pattern_q;
  logic               det_q;
  logic [CNT_W-1:0]   hit_cnt_q;
  logic [CNT_W-1:0]   hit_cnt_d;
  logic               shift_en;
  logic               match;

  // clr blocks both acceptance and bit consumption in the same cycle.
  assign in_ready  = (state_q == IDLE) && !clr;
  assign shift_en  = (state_q == SHIFT) && !clr;
  assign busy      = (state_q == SHIFT);
  assign det       = det_q;
  assign hit_cnt   = hit_cnt_q;
  assign dbg_state = state_q;

  // Saturating increment of the hit counter.
  always_comb begin
    hit_cnt_d = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
  end

  // Data word is left-shifted so the bit to consume is always the MSB.
  seq_match u_match (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .shift_en_i (shift_en),
    .bit_i      (data_q[DATA_W-1]),
    .pattern_i  (pattern_q),
    .match_o    (match)
  );

  // Controller FSM with word latch, bit index, det pulse and hit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      pattern_q <= '0;
      det_q     <= 1'b0;
      hit_cnt_q <= '0;
    end else if (clr) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      det_q     <= 1'b0;
      hit_cnt_q <= '0;
    end else begin
      det_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            data_q    <= in_data;
            pattern_q <= pattern;
            idx_q     <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          data_q <= {data_q[DATA_W-2:0], 1'b0};
          idx_q  <= idx_q + IDX_W'(1);
          if (match) begin
            det_q     <= 1'b1;
            hit_cnt_q <= hit_cnt_d;
          end
          if (idx_q == IDX_LAST) begin
            idx_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SEQ_DET_IRQ_EN
  logic irq_q;

  // Sticky interrupt: set when a match brings the count to the threshold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q <= 1'b0;
    end else if (clr) begin
      irq_q <= 1'b0;
    end else if (match && (hit_cnt_d >= threshold) && (threshold != '0)) begin
      irq_q <= 1'b1;
    end
  end

  assign irq = irq_q;
`else
  logic unused_threshold;

  assign unused_threshold = ^threshold;
  assign irq              = 1'b0;
`endif

endmodule : seq_det_ctrl

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus randomized
// words compared against a bit-queue reference model.
module tb_seq_det_ctrl;
  import seq_det_ctrl_pkg::*;

  localparam int DATA_W  = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ_DET_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [PAT_W-1:0]  pattern;
  logic [CNT_W-1:0]  threshold;
  logic              busy;
  logic              det;
  logic [CNT_W-1:0]  hit_cnt;
  logic              irq;
  state_e            dbg_state;

  always #5 clk = ~clk;

  seq_det_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .pattern   (pattern),
    .threshold (threshold),
    .busy      (busy),
    .det       (det),
    .hit_cnt   (hit_cnt),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / model ----------------
  int compared   = 0;
  int mismatched = 0;
  logic [CNT_W+1:0] exp_q[$];

  bit                m_bits[$];
  logic [DATA_W-1:0] m_word;
  logic [PAT_W-1:0]  m_pat;
  int                m_pos;
  int                m_cnt;
  bit                m_irq;
  int                thr_v;
  int                obs_dets;
  bit                noise_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_bits.delete();
    m_cnt = 0;
    m_irq = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clear();
    check("clr_hit_cnt", 32'(hit_cnt), 0);
    check("clr_irq", 32'(irq), 0);
    check("clr_busy", 32'(busy), 0);
  endtask

  task automatic accept(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p);
    in_valid = 1'b1;
    in_data  = d;
    pattern  = p;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("accept_busy", 32'(busy), 1);
    check("accept_state", 32'(dbg_state), 32'(SHIFT));
    m_word   = d;
    m_pat    = p;
    m_pos    = 0;
    obs_dets = 0;
  endtask

  // Consume n bits, predicting each edge from the bit history queue.
  task automatic run_bits(input int n);
    bit b;
    bit m_det;
    logic [CNT_W+1:0] obs;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      b = m_word[DATA_W-1-m_pos];
      m_pos++;
      m_bits.push_back(b);
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      m_det = (m_bits.size() == PAT_W) &&
              ({m_bits[0], m_bits[1], m_bits[2], m_bits[3]} == m_pat);
      if (m_det) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (IRQ_ON && thr_v != 0 && m_cnt >= thr_v) m_irq = 1'b1;
      end
      exp_q.push_back({m_det, m_irq, CNT_W'(m_cnt)});
      obs = {det, irq, hit_cnt};
      check("bit_det_irq_cnt", 32'(obs), 32'(exp_q.pop_front()));
      check("bit_busy", 32'(busy), 32'(m_pos < DATA_W));
      obs_dets += int'(det);
      if (noise_en && m_pos < DATA_W && k < n) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = DATA_W'($urandom);
        pattern  = PAT_W'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic word(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p);
    accept(d, p);
    run_bits(DATA_W);
    check("word_done_ready", 32'(in_ready), 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; pattern = '0;
    threshold = '0; thr_v = 0; noise_en = 1'b0;
    model_clear();
    #1;
    check("rst_det", 32'(det), 0);
    check("rst_hit_cnt", 32'(hit_cnt), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    #12 rst = 1'b1;
    @(posedge clk); #1;

    // Three overlapping matches inside one word.
    word(8'hAA, 4'b1010);
    check("aa_det_pulses", 32'(obs_dets), 3);
    check("aa_hit_cnt", 32'(hit_cnt), 3);
    do_clr();

    // Match spanning a word boundary.
    word(8'h05, 4'b1010);
    check("w05_det_pulses", 32'(obs_dets), 0);
    word(8'h00, 4'b1010);
    check("w00_det_pulses", 32'(obs_dets), 1);
    check("span_hit_cnt", 32'(hit_cnt), 1);
    do_clr();

    // clr wins over a simultaneous accept.
    clr = 1'b1; in_valid = 1'b1; in_data = 8'hAA; pattern = 4'b1010;
    #1;
    check("clr_blocks_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    clr = 1'b0;
    model_clear();
    check("clr_no_accept_busy", 32'(busy), 0);
    accept(8'hAA, 4'b1010);
    run_bits(DATA_W);
    check("after_clr_hit_cnt", 32'(hit_cnt), 3);
    do_clr();

    // Threshold interrupt.
    thr_v = 2; threshold = 8'd2;
    word(8'hAA, 4'b1010);
    check("thr_irq_after_word", 32'(irq), 32'(IRQ_ON));
    do_clr();

    // Asynchronous reset mid-word discards history and counters.
    word(8'hAA, 4'b1010);
    accept(8'hAA, 4'b1010);
    run_bits(3);
    rst = 1'b0;
    #1;
    check("midrst_det", 32'(det), 0);
    check("midrst_hit_cnt", 32'(hit_cnt), 0);
    check("midrst_irq", 32'(irq), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    model_clear();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    word(8'h0A, 4'b1010);
    check("postrst_det_pulses", 32'(obs_dets), 1);
    check("postrst_hit_cnt", 32'(hit_cnt), 1);
    do_clr();

    // Counter saturation: 3 + 4*65 = 263 hits.
    thr_v = 0; threshold = '0;
    for (int w = 0; w < 66; w++) word(8'hAA, 4'b1010);
    check("sat_hit_cnt", 32'(hit_cnt), CNT_MAX);
    check("sat_last_word_dets", 32'(obs_dets), 4);
    do_clr();

    // Randomized words with bus noise while busy.
    noise_en = 1'b1;
    thr_v = $urandom_range(0, 12);
    threshold = CNT_W'(thr_v);
    for (int w = 0; w < 40; w++) begin
      word(DATA_W'($urandom), PAT_W'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check("idle_det", 32'(det), 0);
      end
      if ($urandom_range(0, 7) == 0) begin
        do_clr();
        thr_v = $urandom_range(0, 12);
        threshold = CNT_W'(thr_v);
      end
    end
    noise_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_seq_det_ctrl

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: width of the parallel input word, serialised MSB first.
REQ-002 Parameter CNT_W, default 8: width of the hit counter and of the threshold.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 clr  input  1  synchronous clear of counter, history, irq and shift activity.
REQ-006 in_valid  input  1  in_data/pattern valid.
REQ-007 in_ready  output  1  block can accept a word (high only in IDLE and clr low).
REQ-008 in_data  input  DATA_W  word to be serialised.
REQ-009 pattern  input  4  target bit pattern, oldest bit in [3]; latched on accept.
REQ-010 threshold  input  CNT_W  hit count that raises irq.
REQ-011 busy  output  1  high while in SHIFT.
REQ-012 det  output  1  one-cycle pulse per pattern match.
REQ-013 hit_cnt  output  CNT_W  saturating match count.
REQ-014 irq  output  1  sticky threshold-reached flag.

Function
REQ-015 FSM SHALL have two states: IDLE and SHIFT.
REQ-016 Accept = in_valid && in_ready. IDLE->SHIFT on accept; in_data and pattern are latched and bit index is set to 0.
REQ-017 In SHIFT, each cycle SHALL consume bit in_data[DATA_W-1-idx]: hist <= {hist[2:0], bit}, idx++.
REQ-018 SHIFT->IDLE on the edge that consumes idx = DATA_W-1; in_ready SHALL be high the following cycle (DATA_W+1 cycles per word minimum).
REQ-019 fill counter SHALL saturate at 4; a match requires fill >= 3 before the consuming edge.
REQ-020 Match SHALL be hist_next == latched pattern; matching SHALL be overlapping.
REQ-021 On a match edge: det <= 1 for exactly the next cycle; hit_cnt <= hit_cnt+1, saturating at all-ones.
REQ-022 hist and fill SHALL persist across words, so matches spanning a word boundary are detected.
REQ-023 clr SHALL win over accept and SHIFT: the word is not accepted, state goes to IDLE, and hist, fill, hit_cnt, det and irq go to 0.
REQ-024 in_valid while busy SHALL be ignored (no accept, no side effect).

Reset
REQ-025 rst low SHALL force state IDLE, idx 0, hist 0, fill 0, det 0, hit_cnt 0 and irq 0, immediately and regardless of clk.
REQ-026 Reset mid-word SHALL discard the partial word; the first accept after release starts with an empty history.

Configuration
REQ-027 Macro SEQ_DET_IRQ_EN defined: irq SHALL be set on the edge where the updated hit_cnt >= threshold and threshold != 0; irq stays high until clr or rst.
REQ-028 Macro SEQ_DET_IRQ_EN undefined: irq SHALL be tied to 0, no compare logic is built, and the threshold input is unused; all ports remain.

Structure
REQ-029 The shared package SHALL hold the state enum (IDLE, SHIFT) and the pattern width constant (4).
REQ-030 Sub-module seq_match SHALL contain hist, fill and the compare logic, and SHALL produce match; the top level holds the FSM, counter and irq.

Verification
REQ-031 pattern 4'b1010, word 8'hAA -> det pulses after bits 4, 6 and 8 (3 pulses); hit_cnt = 3.
REQ-032 pattern 4'b1010, words 8'h05 then 8'h00 -> no det in the first word; one det after bit 1 of the second word; hit_cnt = 1.
REQ-033 CNT_W=8, repeated 8'hAA words until 260 hits -> hit_cnt holds 255 and det still pulses.
REQ-034 SEQ_DET_IRQ_EN, threshold 2, word 8'hAA -> irq rises with the second det and stays high after the word; clr -> irq, hit_cnt = 0.
REQ-035 rst asserted at idx 3 of 8'hAA -> all outputs 0 immediately; after release, word 8'h0A -> exactly one det.
REQ-036 clr and in_valid high in the same IDLE cycle -> no accept, busy stays 0; next cycle the word is accepted.
